cache_control_nway: RTL and testbench
=====================================

Name: cache_control_nway

Overview:
Control and metadata block for a parametrised N-way set-associative, write-back, write-allocate cache.
- Holds the tag, valid, dirty and tree-PLRU state internally.
- Drives an external line-wide data array through way/index selects and write enables, and sequences write-back and fill transfers on the physical-memory handshake.
- Adds a whole-cache flush mode (write back every dirty line) that the single-way controller lacks.
- Sits between the CPU memory port and the pmem/arbiter port.

Parameters:
ADDR_W, 32, address width in bits
LINE_BYTES, 32, bytes per line, power of 2; OFF_W = log2(LINE_BYTES)
SETS, 8, number of sets, power of 2; IDX_W = log2(SETS)
WAYS, 2, associativity, power of 2 in 1..8; WAY_W = max(1, log2(WAYS)); TAG_W = ADDR_W - IDX_W - OFF_W

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
mem_addr  in  ADDR_W  CPU byte address, held stable until mem_resp
mem_read  in  1  CPU read request
mem_write  in  1  CPU write request
mem_resp  out  1  request complete, one cycle per access
flush_req  in  1  level request to write back all dirty lines
flush_done  out  1  one-cycle pulse when flush completes
pmem_addr  out  ADDR_W  line-aligned physical address (low OFF_W bits zero)
pmem_read  out  1  line read request, held until pmem_resp
pmem_write  out  1  line write request, held until pmem_resp
pmem_resp  in  1  pmem transfer complete, one-cycle pulse
way_sel  out  WAY_W  data-array way addressed this cycle
data_idx  out  IDX_W  data-array set addressed this cycle
data_we  out  1  write CPU data (byte-merged externally) into way_sel/data_idx
fill_we  out  1  write pmem line into way_sel/data_idx
datamux_sel  out  1  1 = CPU write data to array, 0 = pmem line to array
hit  out  1  status: lookup hit this cycle

Behaviour:
- Reset (async assert, sync deassert):
  - State = IDLE; all valid, dirty and PLRU bits = 0; flush counter = 0.
  - All outputs 0, including pmem_read/pmem_write mid-transfer, so any in-flight pmem transfer is abandoned.
- States: IDLE, WRITEBACK, FILL, FLUSH_SCAN, FLUSH_WB.
- IDLE lookup is combinational:
  - Fields: idx = mem_addr[OFF_W +: IDX_W], tag = upper TAG_W bits.
  - hit = (mem_read | mem_write) & any way has valid & tag match. Multiple matches cannot occur by construction.
  - data_idx = idx.
- Read hit:
  - mem_resp = 1 in the same cycle; way_sel = hit way.
  - PLRU for the set updated to point away from the hit way.
- Write hit:
  - mem_resp = 1, data_we = 1, datamux_sel = 1 in the same cycle.
  - Dirty bit of the hit way set; PLRU updated.
- Miss, victim selection: lowest-index invalid way, otherwise the PLRU way. The victim is latched at miss detection and held until the fill completes.
- Miss, victim valid & dirty:
  - Go to WRITEBACK: pmem_write = 1, pmem_addr = {victim tag, idx, 0}.
  - On pmem_resp, go to FILL.
- Miss, otherwise: go directly to FILL.
- FILL:
  - pmem_read = 1, pmem_addr = {tag, idx, 0}.
  - On pmem_resp: fill_we = 1, datamux_sel = 0, way_sel = victim; tag written, valid = 1, dirty = 0; return to IDLE.
  - The retried lookup then hits next cycle, so miss latency = pmem latency(s) + 1 cycle.
- mem_resp is never asserted outside IDLE. mem_read and mem_write both high is treated as a write.
- Flush entry: taken from IDLE only when flush_req = 1 and no CPU request is present; the CPU has priority. Enters FLUSH_SCAN with counter {set, way} = 0.
- FLUSH_SCAN:
  - One line examined per cycle; data_idx / way_sel = counter.
  - If the line is valid & dirty, go to FLUSH_WB with pmem_write = 1 and pmem_addr = {stored tag, set, 0}.
  - Otherwise increment the counter.
- FLUSH_WB: on pmem_resp, clear dirty (valid retained), increment the counter, return to FLUSH_SCAN.
- Flush completion:
  - When the counter wraps from SETS*WAYS-1: flush_done pulses one cycle, state returns to IDLE, counter returns to 0.
  - flush_req may drop mid-flush without effect: a started flush always completes.
- WAYS = 1: way_sel is constant 0 and PLRU is unused.

Decomposition:
- Package cache_nway_pkg: state enum, localparam width helpers (clog2-based OFF_W/IDX_W/TAG_W/WAY_W), line-address build function.
- One natural sub-module, plru_tree: per-set PLRU bit storage (WAYS-1 bits/set), victim output for a read index, update-on-access input.

Test Plan:
- Cold read, WAYS=2: read 0x0000_1040 → pmem_read with pmem_addr 0x0000_1040; pmem_resp after 5 cycles → fill_we way 0, then mem_resp next cycle, hit = 1.
- Write hit: write 0x0000_1044 after the fill above → same-cycle mem_resp, data_we = 1, way_sel = 0, dirty set; no pmem activity.
- Dirty eviction: fill ways 0 and 1 of set 2 (tags A, B), dirty A, read B, then miss with tag C → pmem_write to A's line address first, then pmem_read to C's; C lands in way 0.
- Flush: 3 dirty lines across sets 0, 5, 7 → exactly 3 pmem_write transactions, in ascending set/way order; flush_done pulses once; next write-back-free read of those lines hits.
- Priority/races: flush_req asserted together with mem_read → read serviced first, flush starts afterwards; flush_req dropped mid-flush → flush still completes.
- Reset mid-FILL: rst_n low while pmem_read = 1 → pmem_read drops immediately; after release, all lookups miss and the state is IDLE.

Source files
------------

// File: rtl/cache_control_nway_pkg.sv
// Shared types and width helpers for the N-way cache controller.
// Widths are derived from the top-level parameters via the calc_* functions.
package cache_nway_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WRITEBACK  = 3'd1,
      ST_FILL       = 3'd2,
      ST_FLUSH_SCAN = 3'd3,
      ST_FLUSH_WB   = 3'd4
   } state_t;

   localparam int DEF_ADDR_W     = 32;
   localparam int DEF_LINE_BYTES = 32;
   localparam int DEF_SETS       = 8;
   localparam int DEF_WAYS       = 2;

   function automatic int calc_off_w(input int line_bytes);
      return $clog2(line_bytes);
   endfunction

   function automatic int calc_idx_w(input int sets);
      return $clog2(sets);
   endfunction

   // A direct-mapped cache still carries a 1-bit way select tied to zero.
   function automatic int calc_way_w(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   function automatic logic [63:0] line_addr(input logic [63:0] tag_v,
                                             input logic [63:0] idx_v,
                                             input int          idx_bits,
                                             input int          off_bits);
      return (tag_v << (idx_bits + off_bits)) | (idx_v << off_bits);
   endfunction

endpackage

// File: rtl/cache_control_nway_if.sv
// Bus bundle between the cache controller, the CPU port, the pmem port and the data array.
// Handshake: a CPU request is held until the single-cycle mem_resp; pmem_read/pmem_write
// are held until the single-cycle pmem_resp; flush_req is a level, flush_done a pulse.
interface cache_control_nway_if #(
   parameter int ADDR_W = 32,
   parameter int IDX_W  = 3,
   parameter int WAY_W  = 1
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_read;
   logic              mem_write;
   logic              mem_resp;
   logic              flush_req;
   logic              flush_done;
   logic [ADDR_W-1:0] pmem_addr;
   logic              pmem_read;
   logic              pmem_write;
   logic              pmem_resp;
   logic [WAY_W-1:0]  way_sel;
   logic [IDX_W-1:0]  data_idx;
   logic              data_we;
   logic              fill_we;
   logic              datamux_sel;
   logic              hit;
   logic [2:0]        dbg_state;

   modport slave (
      input  mem_addr, mem_read, mem_write, flush_req, pmem_resp,
      output mem_resp, flush_done, pmem_addr, pmem_read, pmem_write,
             way_sel, data_idx, data_we, fill_we, datamux_sel, hit, dbg_state
   );

   modport master (
      output mem_addr, mem_read, mem_write, flush_req, pmem_resp,
      input  mem_resp, flush_done, pmem_addr, pmem_read, pmem_write,
             way_sel, data_idx, data_we, fill_we, datamux_sel, hit, dbg_state
   );
endinterface

// File: rtl/cache_control_nway_plru_tree.sv
// Tree pseudo-LRU state: WAYS-1 bits per set, heap-ordered (node n -> children 2n+1, 2n+2).
// A node bit of 0 points the victim search left, 1 points it right.
module plru_tree
   import cache_nway_pkg::*;
#(
   parameter int SETS  = 8,
   parameter int WAYS  = 2,
   parameter int IDX_W = 3,
   parameter int WAY_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [WAY_W-1:0] victim,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic [WAY_W-1:0] upd_way
);

   generate
      if (WAYS == 1) begin : g_direct
         logic unused_plru;
         assign unused_plru = ^{clk, rst_n, rd_idx, upd_en, upd_idx, upd_way};
         assign victim = '0;
      end else begin : g_tree
         localparam int LEVELS = $clog2(WAYS);

         logic [WAYS-2:0] bits_q [SETS];
         logic [WAYS-2:0] rd_bits;
         logic [WAYS-2:0] upd_bits;
         logic            vbit;
         logic            ubit;
         int              vnode;
         int              unode;

         assign rd_bits = bits_q[rd_idx];

         always_comb begin
            vnode = 0;
            vbit  = 1'b0;
            for (int l = 0; l < LEVELS; l++) begin
               vbit = 1'b0;
               for (int n = 0; n < WAYS - 1; n++)
                  if (n == vnode) vbit = rd_bits[n];
               vnode = 2 * vnode + 1 + (vbit ? 1 : 0);
            end
            victim = WAY_W'(vnode - (WAYS - 1));
         end

         // Every node on the accessed way's path is turned to point away from it.
         always_comb begin
            upd_bits = bits_q[upd_idx];
            unode    = 0;
            ubit     = 1'b0;
            for (int l = 0; l < LEVELS; l++) begin
               ubit = ((int'(upd_way) >> (LEVELS - 1 - l)) & 1) != 0;
               for (int n = 0; n < WAYS - 1; n++)
                  if (n == unode) upd_bits[n] = ~ubit;
               unode = 2 * unode + 1 + (ubit ? 1 : 0);
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
            end else if (upd_en) begin
               bits_q[upd_idx] <= upd_bits;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/cache_control_nway.sv
// Tag/valid/dirty/PLRU controller for an N-way write-back, write-allocate cache with
// whole-cache flush; the line data array lives outside and is steered by way_sel/data_idx.
module cache_control_nway
   import cache_nway_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int LINE_BYTES = DEF_LINE_BYTES,
   parameter int SETS       = DEF_SETS,
   parameter int WAYS       = DEF_WAYS
) (
   input logic                 clk,
   input logic                 rst_n,
   cache_control_nway_if.slave bus
);

   localparam int OFF_W = calc_off_w(LINE_BYTES);
   localparam int IDX_W = calc_idx_w(SETS);
   localparam int WAY_W = calc_way_w(WAYS);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

   function automatic logic [ADDR_W-1:0] mk_addr(input logic [TAG_W-1:0] t,
                                                 input logic [IDX_W-1:0] i);
      return ADDR_W'(line_addr(64'(t), 64'(i), IDX_W, OFF_W));
   endfunction

   state_t            state_q;
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   dirty_q [SETS];
   logic [WAY_W-1:0]  victim_q;
   logic [IDX_W-1:0]  fl_set_q, fl_set_nxt;
   logic [WAY_W-1:0]  fl_way_q, fl_way_nxt;
   logic              pmem_read_q, pmem_write_q;
   logic [ADDR_W-1:0] pmem_addr_q;

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic              req, wr, match, inv_found, fl_last, fl_wb_needed, unused_off;
   logic [WAY_W-1:0]  hit_way, inv_way, plru_way, miss_way;

   assign idx        = bus.mem_addr[OFF_W +: IDX_W];
   assign tag        = bus.mem_addr[ADDR_W-1 -: TAG_W];
   assign unused_off = ^bus.mem_addr[OFF_W-1:0];
   assign req        = bus.mem_read | bus.mem_write;
   assign wr         = bus.mem_write;

   always_comb begin
      match     = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = 0; w < WAYS; w++)
         if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
            match   = 1'b1;
            hit_way = WAY_W'(w);
         end
      // Descending scan leaves the lowest-index invalid way selected.
      for (int w = WAYS - 1; w >= 0; w--)
         if (!valid_q[idx][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
   end

   assign miss_way = inv_found ? inv_way : plru_way;

   plru_tree #(.SETS(SETS), .WAYS(WAYS), .IDX_W(IDX_W), .WAY_W(WAY_W)) u_plru (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_idx  (idx),
      .victim  (plru_way),
      .upd_en  (state_q == ST_IDLE && req && match),
      .upd_idx (idx),
      .upd_way (hit_way)
   );

   assign fl_last      = (fl_set_q == IDX_W'(SETS - 1)) && (fl_way_q == WAY_W'(WAYS - 1));
   assign fl_wb_needed = valid_q[fl_set_q][fl_way_q] && dirty_q[fl_set_q][fl_way_q];

   always_comb begin
      fl_set_nxt = fl_set_q;
      fl_way_nxt = fl_way_q + 1'b1;
      if (fl_way_q == WAY_W'(WAYS - 1)) begin
         fl_way_nxt = '0;
         fl_set_nxt = fl_set_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         victim_q     <= '0;
         fl_set_q     <= '0;
         fl_way_q     <= '0;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
         pmem_addr_q  <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req) begin
                  if (match) begin
                     if (wr) dirty_q[idx][hit_way] <= 1'b1;
                  end else begin
                     victim_q <= miss_way;
                     if (valid_q[idx][miss_way] && dirty_q[idx][miss_way]) begin
                        state_q      <= ST_WRITEBACK;
                        pmem_write_q <= 1'b1;
                        pmem_addr_q  <= mk_addr(tag_q[idx][miss_way], idx);
                     end else begin
                        state_q     <= ST_FILL;
                        pmem_read_q <= 1'b1;
                        pmem_addr_q <= mk_addr(tag, idx);
                     end
                  end
               end else if (bus.flush_req) begin
                  state_q  <= ST_FLUSH_SCAN;
                  fl_set_q <= '0;
                  fl_way_q <= '0;
               end
            end
            ST_WRITEBACK: begin
               if (bus.pmem_resp) begin
                  state_q      <= ST_FILL;
                  pmem_write_q <= 1'b0;
                  pmem_read_q  <= 1'b1;
                  pmem_addr_q  <= mk_addr(tag, idx);
               end
            end
            ST_FILL: begin
               if (bus.pmem_resp) begin
                  state_q                 <= ST_IDLE;
                  pmem_read_q             <= 1'b0;
                  valid_q[idx][victim_q]  <= 1'b1;
                  dirty_q[idx][victim_q]  <= 1'b0;
               end
            end
            ST_FLUSH_SCAN: begin
               if (fl_wb_needed) begin
                  state_q      <= ST_FLUSH_WB;
                  pmem_write_q <= 1'b1;
                  pmem_addr_q  <= mk_addr(tag_q[fl_set_q][fl_way_q], fl_set_q);
               end else begin
                  fl_set_q <= fl_set_nxt;
                  fl_way_q <= fl_way_nxt;
                  if (fl_last) state_q <= ST_IDLE;
               end
            end
            ST_FLUSH_WB: begin
               if (bus.pmem_resp) begin
                  pmem_write_q                <= 1'b0;
                  dirty_q[fl_set_q][fl_way_q] <= 1'b0;
                  fl_set_q                    <= fl_set_nxt;
                  fl_way_q                    <= fl_way_nxt;
                  state_q                     <= fl_last ? ST_IDLE : ST_FLUSH_SCAN;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Tags need no reset: valid bits gate every use.
   always_ff @(posedge clk) begin
      if (state_q == ST_FILL && bus.pmem_resp) tag_q[idx][victim_q] <= tag;
   end

   always_comb begin
      bus.mem_resp    = 1'b0;
      bus.hit         = 1'b0;
      bus.data_we     = 1'b0;
      bus.datamux_sel = 1'b0;
      bus.fill_we     = 1'b0;
      bus.flush_done  = 1'b0;
      bus.way_sel     = '0;
      bus.data_idx    = idx;
      case (state_q)
         ST_IDLE: begin
            bus.hit         = req & match;
            bus.mem_resp    = req & match;
            bus.way_sel     = match ? hit_way : '0;
            bus.data_we     = req & match & wr;
            bus.datamux_sel = req & match & wr;
         end
         ST_WRITEBACK: bus.way_sel = victim_q;
         ST_FILL: begin
            bus.way_sel = victim_q;
            bus.fill_we = bus.pmem_resp;
         end
         ST_FLUSH_SCAN: begin
            bus.way_sel    = fl_way_q;
            bus.data_idx   = fl_set_q;
            bus.flush_done = !fl_wb_needed && fl_last;
         end
         ST_FLUSH_WB: begin
            bus.way_sel    = fl_way_q;
            bus.data_idx   = fl_set_q;
            bus.flush_done = bus.pmem_resp && fl_last;
         end
         default: ;
      endcase
   end

   assign bus.pmem_read  = pmem_read_q;
   assign bus.pmem_write = pmem_write_q;
   assign bus.pmem_addr  = pmem_addr_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_cache_control_nway.sv
// Self-checking bench for cache_control_nway: CPU access tables, pmem responder with an
// expected-transaction queue, flush and reset corner sequences.
module tb_cache_control_nway;
   localparam int ADDR_W     = 32;
   localparam int LINE_BYTES = 32;
   localparam int SETS       = 8;
   localparam int WAYS       = 2;
   localparam int IDX_W      = 3;
   localparam int WAY_W      = 1;
   localparam int LAT        = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   cache_control_nway_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .WAY_W(WAY_W)) bus ();

   cache_control_nway #(.ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .SETS(SETS), .WAYS(WAYS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [ADDR_W:0] exp_q[$];   // {is_write, line address}

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // pmem model: accepts one transfer at a time, answers LAT cycles after seeing it.
   bit busy = 1'b0;
   int cnt  = 0;
   always @(posedge clk) begin
      logic [ADDR_W:0] e;
      #1;
      if (!rst_n) begin
         busy          = 1'b0;
         bus.pmem_resp = 1'b0;
      end else begin
         if (bus.pmem_resp) begin
            bus.pmem_resp = 1'b0;
            busy          = 1'b0;
         end
         if (!busy && (bus.pmem_read || bus.pmem_write)) begin
            busy = 1'b1;
            cnt  = LAT;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pmem_unexpected: got wr=%0b addr=0x%0h expected none",
                        bus.pmem_write, bus.pmem_addr);
            end else begin
               e = exp_q.pop_front();
               check("pmem_txn", 64'({bus.pmem_write, bus.pmem_addr}), 64'(e));
            end
         end else if (busy) begin
            cnt--;
            if (cnt == 0) bus.pmem_resp = 1'b1;
         end
      end
   end

   // Starts and ends at posedge+1; samples at negedge.
   task automatic cpu_access(input string nm, input bit wr, input logic [31:0] addr,
                             input bit exp_hit, input logic [WAY_W-1:0] exp_way);
      bit prev_fill, done;
      bus.mem_addr  = addr;
      bus.mem_read  = !wr;
      bus.mem_write = wr;
      @(negedge clk);
      check({nm, "_hit"}, 64'(bus.hit), 64'(exp_hit));
      check({nm, "_resp"}, 64'(bus.mem_resp), 64'(exp_hit));
      if (exp_hit) begin
         check({nm, "_way"}, 64'(bus.way_sel), 64'(exp_way));
         check({nm, "_data_we"}, 64'(bus.data_we), 64'(wr));
      end else begin
         prev_fill = 1'b0;
         done      = 1'b0;
         for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (bus.mem_resp) begin
               done = 1'b1;
               check({nm, "_fill_then_resp"}, 64'(prev_fill), 64'd1);
               check({nm, "_retry_hit"}, 64'(bus.hit), 64'd1);
               check({nm, "_retry_way"}, 64'(bus.way_sel), 64'(exp_way));
               check({nm, "_retry_data_we"}, 64'(bus.data_we), 64'(wr));
            end else begin
               prev_fill = bus.fill_we;
               if (bus.fill_we) begin
                  check({nm, "_fill_way"}, 64'(bus.way_sel), 64'(exp_way));
                  check({nm, "_fill_mux"}, 64'(bus.datamux_sel), 64'd0);
               end
            end
         end
         if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no mem_resp expected one within 200 cycles", nm);
         end
      end
      @(posedge clk);
      #1;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
   endtask

   typedef struct {
      bit               wr;
      logic [31:0]      addr;
      bit               exp_hit;
      logic [WAY_W-1:0] exp_way;
      bit               has_wb;
      logic [31:0]      wb_addr;
   } vec_t;

   task automatic run_vec(input vec_t v, input string nm);
      if (!v.exp_hit) begin
         if (v.has_wb) exp_q.push_back({1'b1, v.wb_addr});
         exp_q.push_back({1'b0, v.addr & ~32'(LINE_BYTES - 1)});
      end
      cpu_access(nm, v.wr, v.addr, v.exp_hit, v.exp_way);
   endtask

   vec_t tbl_a[12];
   vec_t tbl_b[6];
   vec_t tbl_c[3];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dn, resp_n, done_c;
      bit seen;

      // {wr, addr, exp_hit, exp_way, has_wb, wb_addr}
      tbl_a = '{
         '{1'b0, 32'h0000_1040, 1'b0, 1'b0, 1'b0, 32'h0},           // cold read set 2
         '{1'b1, 32'h0000_1044, 1'b1, 1'b0, 1'b0, 32'h0},           // write hit, dirty A
         '{1'b0, 32'h0000_1048, 1'b1, 1'b0, 1'b0, 32'h0},
         '{1'b0, 32'h0000_2040, 1'b0, 1'b1, 1'b0, 32'h0},           // B into free way 1
         '{1'b1, 32'h0000_1050, 1'b1, 1'b0, 1'b0, 32'h0},
         '{1'b0, 32'h0000_2040, 1'b1, 1'b1, 1'b0, 32'h0},           // B most recent
         '{1'b0, 32'h0000_3040, 1'b0, 1'b0, 1'b1, 32'h0000_1040},   // C evicts dirty A
         '{1'b0, 32'h0000_2044, 1'b1, 1'b1, 1'b0, 32'h0},
         '{1'b0, 32'h0000_1040, 1'b0, 1'b0, 1'b0, 32'h0},           // A evicts clean C
         '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0},           // dirty set 0
         '{1'b1, 32'h0000_40A0, 1'b0, 1'b0, 1'b0, 32'h0},           // dirty set 5
         '{1'b1, 32'h0000_50E0, 1'b0, 1'b0, 1'b0, 32'h0}            // dirty set 7
      };
      tbl_b = '{
         '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0},
         '{1'b0, 32'h0000_40A0, 1'b1, 1'b0, 1'b0, 32'h0},
         '{1'b0, 32'h0000_50E0, 1'b1, 1'b0, 1'b0, 32'h0},
         '{1'b0, 32'h0000_7000, 1'b0, 1'b1, 1'b0, 32'h0},
         '{1'b0, 32'h0000_8000, 1'b0, 1'b0, 1'b0, 32'h0},           // victim cleaned by flush
         '{1'b1, 32'h0000_40A4, 1'b1, 1'b0, 1'b0, 32'h0}
      };
      tbl_c = '{
         '{1'b0, 32'h0000_1040, 1'b0, 1'b0, 1'b0, 32'h0},
         '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0},
         '{1'b0, 32'h0000_1040, 1'b1, 1'b0, 1'b0, 32'h0}
      };

      // Clock/reset
      bus.mem_addr  = '0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.flush_req = 1'b0;
      rst_n         = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_resp", 64'(bus.mem_resp), 64'd0);
      check("rst_pmem_read", 64'(bus.pmem_read), 64'd0);
      check("rst_pmem_write", 64'(bus.pmem_write), 64'd0);
      check("rst_flush_done", 64'(bus.flush_done), 64'd0);
      check("rst_hit", 64'(bus.hit), 64'd0);
      check("rst_fill_we", 64'(bus.fill_we), 64'd0);
      check("rst_state", 64'(bus.dbg_state), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) run_vec(tbl_a[i], $sformatf("a%0d", i));

      // Flush with a simultaneous read: the read wins, then 3 ordered write-backs.
      exp_q.push_back({1'b1, 32'h0000_0000});
      exp_q.push_back({1'b1, 32'h0000_40A0});
      exp_q.push_back({1'b1, 32'h0000_50E0});
      bus.flush_req = 1'b1;
      cpu_access("prio", 1'b0, 32'h0000_1040, 1'b1, 1'b0);
      @(negedge clk);
      check("prio_state_idle", 64'(bus.dbg_state), 64'd0);
      dn     = 0;
      resp_n = 0;
      done_c = -1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (c == 0) check("flush_entered", 64'(bus.dbg_state), 64'd3);
         if (c == 4) bus.flush_req = 1'b0;
         if (bus.flush_done) dn++;
         if (bus.mem_resp) resp_n++;
         if (dn > 0 && done_c < 0) done_c = c;
         if (done_c >= 0 && c >= done_c + 3) break;
      end
      check("flush_done_pulses", 64'(dn), 64'd1);
      check("flush_no_mem_resp", 64'(resp_n), 64'd0);
      check("flush_wb_drained", 64'(exp_q.size()), 64'd0);
      check("flush_state_idle", 64'(bus.dbg_state), 64'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++) run_vec(tbl_b[i], $sformatf("b%0d", i));

      // Reset while a fill is outstanding.
      exp_q.push_back({1'b0, 32'h0000_9020});
      bus.mem_addr = 32'h0000_9020;
      bus.mem_read = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (bus.pmem_read) seen = 1'b1;
      end
      check("rst_fill_started", 64'(seen), 64'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_pmem_read", 64'(bus.pmem_read), 64'd0);
      check("midrst_pmem_write", 64'(bus.pmem_write), 64'd0);
      check("midrst_state", 64'(bus.dbg_state), 64'd0);
      check("midrst_mem_resp", 64'(bus.mem_resp), 64'd0);
      bus.mem_read = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("postrst_state", 64'(bus.dbg_state), 64'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 3; i++) run_vec(tbl_c[i], $sformatf("c%0d", i));

      repeat (3) @(posedge clk);
      check("exp_q_drain", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
